// File: rtl/alu_pipe_flags.sv
// -----------------------------------------------------------------------------
// alu_pipe_flags
//   Registered ALU with N/V/Z condition flags between register-file read and
//   writeback. One operation is accepted per in_valid/in_ready handshake and
//   the result is returned through a single-slot out_valid/out_ready stage.
//   RED (byte reduction) iterates over WIDTH/8 cycles; every other op takes
//   one cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept an operation this cycle
//   op         000 ADD, 001 SUB, 010 RED, 011 XOR,
//              100 SLL, 101 SRA, 110 ROR, 111 PADDSB
//   a, b       operands
//   shamt      shift / rotate amount
//   out_valid  result valid
//   out_ready  consumer accepts result
//   result     registered result
//   flag_n/v/z registered negative / overflow / zero flags
// -----------------------------------------------------------------------------
module alu_pipe_flags #(
  parameter  int WIDTH  = 16,
  parameter  int LANE_W = 4,
  localparam int SHW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_n,
  output logic             flag_v,
  output logic             flag_z
);

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_RED    = 3'b010;
  localparam logic [2:0] OP_XOR    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam int NB     = WIDTH / 8;
  localparam int CW     = $clog2(NB);
  localparam int NLANES = WIDTH / LANE_W;

  typedef enum logic {IDLE = 1'b0, RED_ACC = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               out_valid_q, out_valid_d;
  logic               flag_n_q, flag_n_d;
  logic               flag_v_q, flag_v_d;
  logic               flag_z_q, flag_z_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_cap_q, a_cap_d;
  logic [WIDTH-1:0]   b_cap_q, b_cap_d;

  logic               accept;
  logic               red_last;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath
  // ---------------------------------------------------------------------------
  // One extra bit of headroom: saturation occurred when the two top bits differ.
  logic [WIDTH:0]     sum_ext, diff_ext;
  logic [WIDTH-1:0]   add_res, sub_res;
  logic               add_sat, sub_sat;
  logic [WIDTH-1:0]   padd_res;
  logic [WIDTH-1:0]   alu_res;

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  assign sum_ext  = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign diff_ext = {a[WIDTH-1], a} - {b[WIDTH-1], b};
  assign add_sat  = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
  assign sub_sat  = diff_ext[WIDTH] ^ diff_ext[WIDTH-1];
  assign add_res  = add_sat ? (sum_ext[WIDTH] ? SAT_MIN : SAT_MAX) : sum_ext[WIDTH-1:0];
  assign sub_res  = sub_sat ? (diff_ext[WIDTH] ? SAT_MIN : SAT_MAX) : diff_ext[WIDTH-1:0];

  // Lane-wise saturating add; each lane has its own headroom bit so no carry
  // ever leaks into the neighbouring lane.
  for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
    logic [LANE_W:0] lane_sum;
    assign lane_sum = {a[gi*LANE_W + LANE_W-1], a[gi*LANE_W +: LANE_W]}
                    + {b[gi*LANE_W + LANE_W-1], b[gi*LANE_W +: LANE_W]};
    assign padd_res[gi*LANE_W +: LANE_W] =
        (lane_sum[LANE_W] ^ lane_sum[LANE_W-1])
          ? (lane_sum[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}})
          : lane_sum[LANE_W-1:0];
  end

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:    alu_res = add_res;
      OP_SUB:    alu_res = sub_res;
      OP_XOR:    alu_res = a ^ b;
      OP_SLL:    alu_res = a << shamt;
      OP_SRA:    alu_res = WIDTH'($signed(a) >>> shamt);
      // Rotating the doubled word makes shamt=0 fall out naturally.
      OP_ROR:    alu_res = WIDTH'({a, a} >> shamt);
      OP_PADDSB: alu_res = padd_res;
      default:   alu_res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Reduction byte select
  // ---------------------------------------------------------------------------
  logic [7:0]       a_byte [NB];
  logic [7:0]       b_byte [NB];
  logic [WIDTH-1:0] red_sum;

  for (genvar gi = 0; gi < NB; gi++) begin : g_byte
    assign a_byte[gi] = a_cap_q[gi*8 +: 8];
    assign b_byte[gi] = b_cap_q[gi*8 +: 8];
  end

  assign red_sum = acc_q
                 + {{(WIDTH-8){a_byte[cnt_q][7]}}, a_byte[cnt_q]}
                 + {{(WIDTH-8){b_byte[cnt_q][7]}}, b_byte[cnt_q]};
  assign red_last = (cnt_q == CW'(NB-1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept && op == OP_RED) state_d = RED_ACC;
      RED_ACC: if (red_last)               state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs. No skid buffer, so a new op is taken only if the output
  // slot is empty or being drained this cycle.
  always_comb begin
    in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------------
  // Datapath / flag next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    result_d    = result_q;
    out_valid_d = out_valid_q;
    flag_n_d    = flag_n_q;
    flag_v_d    = flag_v_q;
    flag_z_d    = flag_z_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    a_cap_d     = a_cap_q;
    b_cap_d     = b_cap_q;

    if (out_ready) out_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (op == OP_RED) begin
            a_cap_d = a;
            b_cap_d = b;
            acc_d   = '0;
            cnt_d   = '0;
          end else begin
            result_d    = alu_res;
            out_valid_d = 1'b1;
            unique case (op)
              OP_ADD, OP_SUB: begin
                flag_n_d = alu_res[WIDTH-1];
                flag_v_d = (op == OP_ADD) ? add_sat : sub_sat;
                flag_z_d = (alu_res == '0);
              end
              OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_z_d = (alu_res == '0);
              default: ;  // PADDSB leaves flags untouched
            endcase
          end
        end
      end
      RED_ACC: begin
        if (red_last) begin
          result_d    = red_sum;
          out_valid_d = 1'b1;
          acc_d       = '0;
          cnt_d       = '0;
        end else begin
          acc_d = red_sum;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q    <= '0;
      out_valid_q <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      acc_q       <= '0;
      cnt_q       <= '0;
      a_cap_q     <= '0;
      b_cap_q     <= '0;
    end else begin
      result_q    <= result_d;
      out_valid_q <= out_valid_d;
      flag_n_q    <= flag_n_d;
      flag_v_q    <= flag_v_d;
      flag_z_q    <= flag_z_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      a_cap_q     <= a_cap_d;
      b_cap_q     <= b_cap_d;
    end
  end

  assign result    = result_q;
  assign out_valid = out_valid_q;
  assign flag_n    = flag_n_q;
  assign flag_v    = flag_v_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_alu_pipe_flags.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe_flags
//   Directed-vector bench for alu_pipe_flags (WIDTH=16, LANE_W=4). Expected
//   values are hand-computed constants; each check is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_alu_pipe_flags;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_RED    = 3'b010;
  localparam logic [2:0] OP_XOR    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [15:0] a, b;
  logic [3:0]  shamt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        flag_n, flag_v, flag_z;

  int n_cmp = 0;
  int n_err = 0;

  alu_pipe_flags #(.WIDTH(16), .LANE_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flag_n    (flag_n),
    .flag_v    (flag_v),
    .flag_z    (flag_z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // flags packed as {N,V,Z}
  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk(tag, {29'd0, flag_n, flag_v, flag_z}, {29'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                       input logic [3:0] sh);
    in_valid = 1'b1;
    op       = o;
    a        = va;
    b        = vb;
    shamt    = sh;
  endtask

  // Issue one op (block assumed ready), take the accept edge, drop in_valid.
  task automatic issue(input logic [2:0] o, input logic [15:0] va, input logic [15:0] vb,
                       input logic [3:0] sh);
    drive(o, va, vb, sh);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic chk_res(input string tag, input logic [15:0] r, input logic [2:0] f);
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_result"}, {16'd0, result}, {16'd0, r});
    chk_flags({tag, "_flags"}, f);
    $display("txn %-10s result=0x%04h nvz=%b%b%b", tag, result, flag_n, flag_v, flag_z);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = OP_ADD; a = '0; b = '0; shamt = '0;
    out_ready = 1'b1;
    tick(); tick();
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk_flags("rst_flags", 3'b000);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Saturating ADD / SUB
    drive(OP_ADD, 16'h7FFF, 16'h0001, 4'd0);
    #1 chk("add_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk_res("add_posov", 16'h7FFF, 3'b010);
    issue(OP_SUB, 16'h1234, 16'h1234, 4'd0);
    chk_res("sub_zero", 16'h0000, 3'b001);
    issue(OP_SUB, 16'h8000, 16'h0001, 4'd0);
    chk_res("sub_negov", 16'h8000, 3'b110);

    // RED: 2-cycle latency, in_ready low, flags untouched
    issue(OP_RED, 16'h7F80, 16'h0101, 4'd0);
    chk("red_c0_valid", {31'd0, out_valid}, 32'd0);
    chk("red_c0_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk("red_c1_valid", {31'd0, out_valid}, 32'd0);
    chk("red_c1_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk_res("red", 16'h0001, 3'b110);
    chk("red_done_ready", {31'd0, in_ready}, 32'd1);

    // PADDSB lanes saturate independently, flags untouched
    issue(OP_PADDSB, 16'h7777, 16'h1111, 4'd0);
    chk_res("padd_pos", 16'h7777, 3'b110);
    issue(OP_PADDSB, 16'h8888, 16'hFFFF, 4'd0);
    chk_res("padd_neg", 16'h8888, 3'b110);

    // Logic/shift ops touch Z only
    issue(OP_XOR, 16'h5A5A, 16'h5A5A, 4'd0);
    chk_res("xor_zero", 16'h0000, 3'b111);
    issue(OP_SRA, 16'h8000, 16'h0000, 4'd15);
    chk_res("sra15", 16'hFFFF, 3'b110);
    issue(OP_ROR, 16'h0001, 16'h0000, 4'd1);
    chk_res("ror1", 16'h8000, 3'b110);
    issue(OP_SLL, 16'h0003, 16'h0000, 4'd4);
    chk_res("sll4", 16'h0030, 3'b110);
    issue(OP_ROR, 16'hA5C3, 16'h0000, 4'd0);
    chk_res("ror0", 16'hA5C3, 3'b110);
    issue(OP_ADD, 16'h8000, 16'hFFFF, 4'd0);
    chk_res("add_negov", 16'h8000, 3'b110);
    issue(OP_ADD, 16'h0005, 16'h0003, 4'd0);
    chk_res("add_plain", 16'h0008, 3'b000);

    // Back-to-back at 1 op/cycle: drive continuously across edges
    drive(OP_XOR, 16'h00F0, 16'h000F, 4'd0);
    tick();
    chk_res("b2b_xor", 16'h00FF, 3'b000);
    drive(OP_SUB, 16'h0001, 16'h0002, 4'd0);
    tick(); in_valid = 1'b0;
    chk_res("b2b_sub", 16'hFFFF, 3'b100);

    // Backpressure: result and flags hold, next op taken on release
    out_ready = 1'b0;
    drive(OP_XOR, 16'h0001, 16'h0001, 4'd0);
    #1 chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    chk_res("bp_hold1", 16'hFFFF, 3'b100);
    tick();
    chk_res("bp_hold2", 16'hFFFF, 3'b100);
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick(); in_valid = 1'b0;
    chk_res("bp_xor", 16'h0000, 3'b101);
    tick();
    chk("bp_drained", {31'd0, out_valid}, 32'd0);
    chk_flags("bp_flags_once", 3'b101);

    // Reset one cycle into RED_ACC
    issue(OP_RED, 16'h0102, 16'h0304, 4'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_red_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_red_result", {16'd0, result}, 32'd0);
    chk_flags("rst_red_flags", 3'b000);
    tick();
    rst_n = 1'b1;
    #1 chk("rst_red_in_ready", {31'd0, in_ready}, 32'd1);
    tick(); tick();
    chk("rst_red_no_stale_v", {31'd0, out_valid}, 32'd0);
    chk("rst_red_no_stale_r", {16'd0, result}, 32'd0);

    // Fresh RED runs after the abort
    issue(OP_RED, 16'h0102, 16'h0304, 4'd0);
    tick(); tick();
    chk_res("red_pos", 16'h000A, 3'b000);
    issue(OP_RED, 16'h8080, 16'h8080, 4'd0);
    tick(); tick();
    chk_res("red_neg", 16'hFE00, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_pipe_flags.md
Name: alu_pipe_flags

Overview:
Parametrised, registered successor to the single-cycle datapath ALU. It accepts one operation per valid/ready handshake and returns a registered result through an output handshake. It owns the N/V/Z condition-flag register with per-opcode update rules. Reduction (RED) runs as a multi-cycle iterative accumulator; every other op completes in one cycle. The block sits between the register-file read stage and writeback in the pipelined core.

Parameters:
WIDTH, 16, datapath width; multiple of 8, >= 16
LANE_W, 4, PADDSB sub-word width; must divide WIDTH
SHW, $clog2(WIDTH), shift-amount width (localparam, derived)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operation request
in_ready  out  1  block can accept an operation this cycle
op  in  3  000 ADD, 001 SUB, 010 RED, 011 XOR, 100 SLL, 101 SRA, 110 ROR, 111 PADDSB
a  in  WIDTH  operand 1
b  in  WIDTH  operand 2
shamt  in  SHW  shift/rotate amount
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
result  out  WIDTH  registered result
flag_n  out  1  negative flag (registered)
flag_v  out  1  overflow/saturation flag (registered)
flag_z  out  1  zero flag (registered)

Behaviour:
- Reset (async, rst_n=0): state=IDLE; result=0; out_valid=0; flag_n/v/z=0; accumulator and counter=0. Reset mid-RED aborts it with no output and no flag change.
- Accept: the handshake fires when in_valid && in_ready. in_ready = (state==IDLE) && (!out_valid || out_ready). This is a single output slot with no skid buffer.
- States: IDLE, RED_ACC.
  - IDLE: on a non-RED accept, result/out_valid load on the next edge (latency 1).
  - IDLE: on a RED accept, capture a and b, clear the accumulator, and go to RED_ACC.
  - RED_ACC: each cycle, add one signed byte of a and one signed byte of b (byte index = counter) into the accumulator.
  - RED_ACC: after WIDTH/8 cycles, load result, set out_valid, return to IDLE. in_ready stays 0 throughout RED_ACC.
  - RED latency = WIDTH/8 cycles from the accept edge to out_valid.
- out_valid clears on out_ready when no new result loads the same edge. Back-to-back ops with out_ready=1 sustain 1 op/cycle for non-RED ops.
- result holds stable while out_valid && !out_ready.
- ADD/SUB: signed, saturating. Positive overflow gives 0x7F..F; negative overflow gives 0x80..0. V=1 iff saturated. SUB is a-b.
- RED: signed sum of all 2*WIDTH/8 signed bytes of a and b, sign-extended to WIDTH.
- XOR: a^b.
- SLL: a<<shamt, logical.
- SRA: arithmetic right shift by shamt.
- ROR: rotate a right by shamt. shamt=0 passes a unchanged for all three shift ops.
- PADDSB: independent signed saturating add per LANE_W lane. No carry crosses lanes.
- Flags update on the same edge the result register loads, once per operation regardless of backpressure:
  - ADD, SUB: N=result[WIDTH-1], V=saturated, Z=(result==0).
  - XOR, SLL, SRA, ROR: Z only; N and V hold.
  - RED, PADDSB: no flag change.
- Z is evaluated on the final (saturated) result.

Test Plan:
- WIDTH=16, ADD a=0x7FFF b=0x0001 -> result 0x7FFF one cycle after accept; N=0 V=1 Z=0.
- SUB a=0x1234 b=0x1234 -> 0x0000, Z=1 N=0 V=0. Then SUB a=0x8000 b=0x0001 -> 0x8000, N=1 V=1 Z=0.
- RED a=0x7F80 b=0x0101 -> 0x0001. out_valid is exactly 2 cycles after accept, in_ready=0 during RED_ACC, and flags are unchanged.
- PADDSB a=0x7777 b=0x1111 -> 0x7777. PADDSB a=0x8888 b=0xFFFF -> 0x8888. Then SRA a=0x8000 shamt=15 -> 0xFFFF with Z=0 and N/V held. ROR a=0x0001 shamt=1 -> 0x8000.
- Backpressure: hold out_ready=0 with in_valid=1 -> in_ready=0 and result held. Flags change only once. Releasing out_ready accepts the next op on that edge.
- Pull rst_n low one cycle into RED_ACC -> out_valid=0 and flags=0 immediately. in_ready=1 the first cycle after release, and no stale result appears.
